// File: rtl/register_file_mp.sv
// Multi-port register file: two write ports (wr1 has priority), N combinational read ports,
// write-to-read bypass, optional hardwired zero register, pending scoreboard and a sweep-clear engine.
module register_file_mp #(
   parameter int DATA_W   = 16,
   parameter int ADDR_W   = 4,
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1,
   parameter int BYPASS   = 1
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
   output logic [NUM_RD*DATA_W-1:0]   rd_data,
   output logic [NUM_RD-1:0]          rd_pending,
   input  logic                       wr0_en,
   input  logic [ADDR_W-1:0]          wr0_addr,
   input  logic [DATA_W-1:0]          wr0_data,
   input  logic                       wr1_en,
   input  logic [ADDR_W-1:0]          wr1_addr,
   input  logic [DATA_W-1:0]          wr1_data,
   input  logic                       sb_set_en,
   input  logic [ADDR_W-1:0]          sb_set_addr,
   input  logic                       clr_req,
   output logic                       clr_busy
);

   localparam int DEPTH = 2**ADDR_W;

   typedef enum logic [0:0] {IDLE = 1'b0, CLEAR = 1'b1} state_t;

   state_t              state_r;
   logic [ADDR_W-1:0]   cnt_r;
   logic [DATA_W-1:0]   mem_r [DEPTH];
   logic [DEPTH-1:0]    sb_r;

   logic                idle_s;
   logic                we0_s;
   logic                we1_s;
   logic                sb_set_s;
   logic [ADDR_W-1:0]   a_s;
   logic                hit0_s;
   logic                hit1_s;
   logic                keep_s;
   logic [DATA_W-1:0]   d_s;
   logic                p_s;

   // Qualified write/set strobes: dropped during the sweep and, with ZERO_REG, at address 0.
   always_comb begin
      idle_s   = (state_r == IDLE);
      we0_s    = wr0_en    && idle_s && !((ZERO_REG != 0) && (wr0_addr    == '0));
      we1_s    = wr1_en    && idle_s && !((ZERO_REG != 0) && (wr1_addr    == '0));
      sb_set_s = sb_set_en && idle_s && !((ZERO_REG != 0) && (sb_set_addr == '0));
   end

   // Read ports with bypass; a matching write hides pending unless a new producer claims the register.
   always_comb begin
      rd_data    = '0;
      rd_pending = '0;
      a_s        = '0;
      hit0_s     = 1'b0;
      hit1_s     = 1'b0;
      keep_s     = 1'b0;
      d_s        = '0;
      p_s        = 1'b0;
      for (int i = 0; i < NUM_RD; i++) begin
         a_s    = rd_addr[i*ADDR_W +: ADDR_W];
         hit0_s = we0_s && (wr0_addr == a_s);
         hit1_s = we1_s && (wr1_addr == a_s);
         keep_s = sb_set_s && (sb_set_addr == a_s);
         if (reset) begin
            d_s = '0;
            p_s = 1'b0;
         end else if ((ZERO_REG != 0) && (a_s == '0)) begin
            d_s = '0;
            p_s = 1'b0;
         end else if ((BYPASS != 0) && hit1_s) begin
            d_s = wr1_data;
            p_s = keep_s & sb_r[a_s];
         end else if ((BYPASS != 0) && hit0_s) begin
            d_s = wr0_data;
            p_s = keep_s & sb_r[a_s];
         end else begin
            d_s = mem_r[a_s];
            p_s = sb_r[a_s];
         end
         rd_data[i*DATA_W +: DATA_W] = d_s;
         rd_pending[i]               = p_s;
      end
   end

   // Storage, scoreboard and sweep-clear FSM.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r <= IDLE;
         cnt_r   <= '0;
         sb_r    <= '0;
         for (int j = 0; j < DEPTH; j++) begin
            mem_r[j] <= '0;
         end
      end else begin
         case (state_r)
            IDLE: begin
               if (we0_s) begin
                  mem_r[wr0_addr] <= wr0_data;
                  sb_r[wr0_addr]  <= 1'b0;
               end
               if (we1_s) begin
                  mem_r[wr1_addr] <= wr1_data;
                  sb_r[wr1_addr]  <= 1'b0;
               end
               // A set issued alongside a write belongs to a newer producer, so it lands last.
               if (sb_set_s) begin
                  sb_r[sb_set_addr] <= 1'b1;
               end
               if (clr_req) begin
                  state_r <= CLEAR;
                  cnt_r   <= '0;
                  sb_r    <= '0;
               end
            end
            CLEAR: begin
               mem_r[cnt_r] <= '0;
               if (cnt_r == {ADDR_W{1'b1}}) begin
                  state_r <= IDLE;
                  cnt_r   <= '0;
               end else begin
                  cnt_r <= cnt_r + 1'b1;
               end
            end
            default: begin
               state_r <= IDLE;
               cnt_r   <= '0;
            end
         endcase
      end
   end

   assign clr_busy = (state_r == CLEAR);

endmodule

// File: tb/tb_register_file_mp.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model,
// on two instances (bypass + zero register, and plain storage without either).
module tb_register_file_mp;

   logic        clk;
   logic        reset;
   logic [7:0]  rd_addr;
   logic        wr0_en, wr1_en, sb_set_en, clr_req;
   logic [3:0]  wr0_addr, wr1_addr, sb_set_addr;
   logic [15:0] wr0_data, wr1_data;
   logic [31:0] rd_data_a, rd_data_b;
   logic [1:0]  rd_pending_a, rd_pending_b;
   logic        clr_busy_a, clr_busy_b;

   int n_tests = 0;
   int n_fail  = 0;

   // model state: instance 0 has bypass and zero register, instance 1 has neither
   logic [15:0] m_mem [2][16];
   logic        m_sb  [2][16];
   bit          m_busy;
   int          m_cnt;

   register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_a (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_a), .rd_pending(rd_pending_a),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clr_req(clr_req), .clr_busy(clr_busy_a));

   register_file_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) u_b (
      .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b), .rd_pending(rd_pending_b),
      .wr0_en(wr0_en), .wr0_addr(wr0_addr), .wr0_data(wr0_data),
      .wr1_en(wr1_en), .wr1_addr(wr1_addr), .wr1_data(wr1_data),
      .sb_set_en(sb_set_en), .sb_set_addr(sb_set_addr), .clr_req(clr_req), .clr_busy(clr_busy_b));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 16; a++) begin
            m_mem[k][a] = 16'h0000;
            m_sb[k][a]  = 1'b0;
         end
      end
      m_busy = 1'b0;
      m_cnt  = 0;
   endtask

   function automatic logic [16:0] model_read(input int k, input int i);
      logic [3:0]  a;
      logic [15:0] d;
      logic        p;
      bit          z, w0, w1, s;
      a = rd_addr[i*4 +: 4];
      if (reset) return 17'h00000;
      z  = (k == 0);
      w0 = wr0_en    && !m_busy && !(z && wr0_addr    == 4'd0);
      w1 = wr1_en    && !m_busy && !(z && wr1_addr    == 4'd0);
      s  = sb_set_en && !m_busy && !(z && sb_set_addr == 4'd0);
      d  = m_mem[k][a];
      p  = m_sb[k][a];
      if (k == 0 && !m_busy) begin
         if (w1 && wr1_addr == a)      d = wr1_data;
         else if (w0 && wr0_addr == a) d = wr0_data;
         if (((w1 && wr1_addr == a) || (w0 && wr0_addr == a)) && !(s && sb_set_addr == a)) p = 1'b0;
      end
      if (z && a == 4'd0) begin
         d = 16'h0000;
         p = 1'b0;
      end
      return {p, d};
   endfunction

   task automatic model_step();
      bit z, w0, w1, s;
      if (m_busy) begin
         for (int k = 0; k < 2; k++) m_mem[k][m_cnt] = 16'h0000;
         if (m_cnt == 15) begin
            m_busy = 1'b0;
            m_cnt  = 0;
         end else begin
            m_cnt++;
         end
      end else begin
         for (int k = 0; k < 2; k++) begin
            z  = (k == 0);
            w0 = wr0_en    && !(z && wr0_addr    == 4'd0);
            w1 = wr1_en    && !(z && wr1_addr    == 4'd0);
            s  = sb_set_en && !(z && sb_set_addr == 4'd0);
            if (w0) begin m_mem[k][wr0_addr] = wr0_data; m_sb[k][wr0_addr] = 1'b0; end
            if (w1) begin m_mem[k][wr1_addr] = wr1_data; m_sb[k][wr1_addr] = 1'b0; end
            if (s) m_sb[k][sb_set_addr] = 1'b1;
            if (clr_req) for (int a = 0; a < 16; a++) m_sb[k][a] = 1'b0;
         end
         if (clr_req) begin
            m_busy = 1'b1;
            m_cnt  = 0;
         end
      end
   endtask

   task automatic compare_all();
      logic [16:0] e;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 2; i++) begin
            e = model_read(k, i);
            check_value($sformatf("inst%0d rd_data%0d", k, i),
                        32'((k == 0) ? rd_data_a[i*16 +: 16] : rd_data_b[i*16 +: 16]), 32'(e[15:0]));
            check_value($sformatf("inst%0d rd_pending%0d", k, i),
                        32'((k == 0) ? rd_pending_a[i] : rd_pending_b[i]), 32'(e[16]));
         end
      end
      check_value("inst0 clr_busy", 32'(clr_busy_a), 32'(m_busy));
      check_value("inst1 clr_busy", 32'(clr_busy_b), 32'(m_busy));
   endtask

   task automatic idle_inputs();
      wr0_en = 1'b0; wr0_addr = 4'd0; wr0_data = 16'h0000;
      wr1_en = 1'b0; wr1_addr = 4'd0; wr1_data = 16'h0000;
      sb_set_en = 1'b0; sb_set_addr = 4'd0; clr_req = 1'b0;
   endtask

   task automatic settle();
      @(negedge clk);
      compare_all();
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
   endtask

   int nb;

   initial begin
      reset = 1'b1;
      rd_addr = 8'h00;
      idle_inputs();
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      compare_all();
      check_value("reset rd_data", rd_data_a, 32'h0000_0000);
      reset = 1'b0;

      // write / read
      wr0_en = 1'b1; wr0_addr = 4'd3; wr0_data = 16'hBEEF; rd_addr = {4'd0, 4'd3};
      settle(); tick();
      idle_inputs(); rd_addr = {4'd4, 4'd3};
      settle();
      check_value("wr_rd R3", 32'(rd_data_a[15:0]), 32'h0000_BEEF);
      check_value("unwritten R4", 32'(rd_data_a[31:16]), 32'h0000_0000);
      tick();

      // port conflict and bypass
      wr0_en = 1'b1; wr0_addr = 4'd5; wr0_data = 16'h1111;
      wr1_en = 1'b1; wr1_addr = 4'd5; wr1_data = 16'h2222; rd_addr = {4'd5, 4'd3};
      settle();
      check_value("bypass wr1 wins", 32'(rd_data_a[31:16]), 32'h0000_2222);
      check_value("no bypass old", 32'(rd_data_b[31:16]), 32'h0000_0000);
      tick();
      idle_inputs();
      settle();
      check_value("R5 stored", 32'(rd_data_a[31:16]), 32'h0000_2222);
      check_value("R5 stored nb", 32'(rd_data_b[31:16]), 32'h0000_2222);
      tick();

      // zero register
      wr0_en = 1'b1; wr0_addr = 4'd0; wr0_data = 16'hFFFF; rd_addr = {4'd0, 4'd0};
      settle(); check_value("R0 write cyc", 32'({rd_pending_a[0], rd_data_a[15:0]}), 32'h0); tick();
      idle_inputs(); sb_set_en = 1'b1; sb_set_addr = 4'd0;
      settle(); check_value("R0 set cyc", 32'({rd_pending_a[0], rd_data_a[15:0]}), 32'h0); tick();
      idle_inputs();
      settle(); check_value("R0 after", 32'({rd_pending_a[0], rd_data_a[15:0]}), 32'h0); tick();

      // scoreboard
      sb_set_en = 1'b1; sb_set_addr = 4'd7; rd_addr = {4'd0, 4'd7};
      settle(); tick();
      idle_inputs();
      settle(); check_value("R7 pending", 32'(rd_pending_a[0]), 32'h1); tick();
      wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 16'h0077;
      settle(); check_value("R7 bypass pend", 32'(rd_pending_a[0]), 32'h0); tick();
      idle_inputs();
      settle(); check_value("R7 retired", 32'(rd_pending_a[0]), 32'h0); tick();
      sb_set_en = 1'b1; sb_set_addr = 4'd7;
      settle(); tick();
      sb_set_en = 1'b1; sb_set_addr = 4'd7; wr0_en = 1'b1; wr0_addr = 4'd7; wr0_data = 16'h0078;
      settle(); check_value("R7 set+wr cyc", 32'(rd_pending_a[0]), 32'h1); tick();
      idle_inputs();
      settle(); check_value("R7 set wins", 32'(rd_pending_a[0]), 32'h1); tick();

      // sweep clear
      for (int r = 1; r < 16; r++) begin
         wr0_en = 1'b1; wr0_addr = 4'(r); wr0_data = 16'h1000 + 16'(r); rd_addr = {4'(r), 4'(r)};
         settle(); tick();
      end
      idle_inputs(); clr_req = 1'b1; wr1_en = 1'b1; wr1_addr = 4'd4; wr1_data = 16'h4444;
      settle(); tick();
      nb = 0;
      for (int c = 0; c < 40; c++) begin
         idle_inputs(); rd_addr = {4'd2, 4'd2};
         if (nb == 3) begin wr0_en = 1'b1; wr0_addr = 4'd2; wr0_data = 16'hABCD; end
         if (nb == 6) begin clr_req = 1'b1; sb_set_en = 1'b1; sb_set_addr = 4'd9; end
         settle();
         if (!clr_busy_a) break;
         nb++;
         tick();
      end
      check_value("sweep length", 32'(nb), 32'd16);
      tick();
      for (int r = 0; r < 16; r++) begin
         rd_addr = {4'(r), 4'(r)};
         settle();
         check_value($sformatf("swept R%0d", r), rd_data_b, 32'h0000_0000);
         tick();
      end

      // async reset mid-sweep
      wr0_en = 1'b1; wr0_addr = 4'd6; wr0_data = 16'h6666; rd_addr = {4'd6, 4'd0};
      settle(); tick();
      idle_inputs(); clr_req = 1'b1;
      settle(); tick();
      idle_inputs();
      repeat (5) begin settle(); tick(); end
      wr0_en = 1'b1; wr0_addr = 4'd6; wr0_data = 16'h5A5A;
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      compare_all();
      check_value("abort busy", 32'(clr_busy_a), 32'h0);
      check_value("abort rd", rd_data_b, 32'h0000_0000);
      idle_inputs();
      @(negedge clk);
      reset = 1'b0;
      wr0_en = 1'b1; wr0_addr = 4'd9; wr0_data = 16'h00A5; rd_addr = {4'd0, 4'd9};
      tick();
      idle_inputs();
      settle(); check_value("post reset R9", 32'(rd_data_a[15:0]), 32'h0000_00A5); tick();

      // random traffic
      for (int c = 0; c < 400; c++) begin
         rd_addr     = 8'($urandom);
         wr0_en      = 1'($urandom_range(0, 1));
         wr0_addr    = 4'($urandom);
         wr0_data    = 16'($urandom);
         wr1_en      = ($urandom_range(0, 3) == 0);
         wr1_addr    = ($urandom_range(0, 1) == 0) ? wr0_addr : 4'($urandom);
         wr1_data    = 16'($urandom);
         sb_set_en   = 1'($urandom_range(0, 1));
         sb_set_addr = ($urandom_range(0, 2) == 0) ? wr0_addr : 4'($urandom);
         clr_req     = ($urandom_range(0, 59) == 0);
         if ($urandom_range(0, 3) == 0) rd_addr[3:0] = sb_set_addr;
         settle();
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
